// File: rtl/cnn_layer_accel_weight_table_ctrl.sv
// cnn_layer_accel_weight_table_ctrl
//
// Job-level sequencer for the CE weight table. The block accepts one job
// descriptor and streams (num_kernels+1) 3x3 kernels of weights into the
// table in config mode. It then issues the per-cycle weight sequence
// addresses for every kernel, and returns to idle once the table reports
// last_kernel.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   job_valid/ready    job descriptor handshake (ready only in IDLE)
//   job_num_kernels    kernels in job minus 1
//   wht_in_*           weight word stream (ready only in LOAD)
//   exec_stall         freezes EXEC stepping while high
//   last_kernel        table's delayed "final kernel reached" flag
//   config_mode        table in config (write) mode
//   job_accept         1-cycle pulse after the job handshake
//   num_kernels        latched job_num_kernels
//   wht_config_*       table write strobe / data
//   wht_seq_addr0/1    even/odd weight index of the current step
//   wht_seq_pad        lane 1 points past the last weight (zero-masked)
//   ce_execute         table read enable request
//   next_kernel        pulse with each kernel's final step
//   job_done           1-cycle pulse when the job is complete
//
// Handshake: a transfer happens on a rising edge where both valid and ready
// are high. Ready is registered and depends only on state; valid may depend
// on ready.
module cnn_layer_accel_weight_table_ctrl #(
  parameter int C_KERNEL_WORDS = 9,
  parameter int C_SEQ_LEN      = 5,
  parameter int C_NK_WIDTH     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [C_NK_WIDTH-1:0] job_num_kernels,
  input  logic                  wht_in_valid,
  output logic                  wht_in_ready,
  input  logic [15:0]           wht_in_data,
  input  logic                  exec_stall,
  input  logic                  last_kernel,
  output logic                  config_mode,
  output logic                  job_accept,
  output logic [C_NK_WIDTH-1:0] num_kernels,
  output logic                  wht_config_wren,
  output logic [15:0]           wht_config_data,
  output logic [3:0]            wht_seq_addr0,
  output logic [3:0]            wht_seq_addr1,
  output logic                  wht_seq_pad,
  output logic                  ce_execute,
  output logic                  next_kernel,
  output logic                  job_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [3:0] WORD_LAST = 4'(C_KERNEL_WORDS - 1);
  localparam logic [2:0] STEP_LAST = 3'(C_SEQ_LEN - 1);
  localparam logic [4:0] PAD_FROM  = 5'(C_KERNEL_WORDS);

  logic [2:0]            state_q, state_d;
  logic [3:0]            word_cnt_q, word_cnt_d;
  logic [2:0]            step_q, step_d;
  logic [C_NK_WIDTH:0]   kern_cnt_q, kern_cnt_d;
  logic [C_NK_WIDTH-1:0] num_kernels_q, num_kernels_d;

  logic                  job_ready_q, job_ready_d;
  logic                  wht_in_ready_q, wht_in_ready_d;
  logic                  config_mode_q, config_mode_d;
  logic                  job_accept_q, job_accept_d;
  logic                  wren_q, wren_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [3:0]            addr0_q, addr0_d;
  logic [3:0]            addr1_q, addr1_d;
  logic                  pad_q, pad_d;
  logic                  ce_execute_q, ce_execute_d;
  logic                  next_kernel_q, next_kernel_d;
  logic                  job_done_q, job_done_d;

  logic                  kern_last;

  // kern_cnt is one bit wider than num_kernels so it never wraps at max.
  assign kern_last = (kern_cnt_q == {1'b0, num_kernels_q});

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    step_d        = step_q;
    kern_cnt_d    = kern_cnt_q;
    num_kernels_d = num_kernels_q;
    job_accept_d  = 1'b0;
    wren_d        = 1'b0;
    wdata_d       = wdata_q;
    addr0_d       = addr0_q;
    addr1_d       = addr1_q;
    pad_d         = pad_q;
    ce_execute_d  = 1'b0;
    next_kernel_d = 1'b0;
    job_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          num_kernels_d = job_num_kernels;
          job_accept_d  = 1'b1;
          state_d       = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        // One quiet cycle so the table can clear its own counters.
        word_cnt_d = '0;
        kern_cnt_d = '0;
        step_d     = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (wht_in_valid) begin
          wren_d  = 1'b1;
          wdata_d = wht_in_data;
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = '0;
            if (kern_last) begin
              kern_cnt_d = '0;
              state_d    = S_EXEC;
            end else begin
              kern_cnt_d = kern_cnt_q + 1'b1;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_EXEC: begin
        // Addresses always show the pending step, so a stall presents the
        // step that will issue when the stall clears.
        addr0_d = {step_q, 1'b0};
        addr1_d = {step_q, 1'b1};
        pad_d   = ({1'b0, step_q, 1'b1} >= PAD_FROM);
        if (!exec_stall) begin
          ce_execute_d = 1'b1;
          if (step_q == STEP_LAST) begin
            step_d        = '0;
            next_kernel_d = 1'b1;
            if (kern_last) begin
              kern_cnt_d = '0;
              state_d    = S_DRAIN;
            end else begin
              kern_cnt_d = kern_cnt_q + 1'b1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (last_kernel) begin
          job_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    job_ready_d    = (state_d == S_IDLE);
    wht_in_ready_d = (state_d == S_LOAD);
    // Stays high one cycle past LOAD so the final registered write lands
    // while the table is still in config mode.
    config_mode_d  = (state_d == S_ACCEPT) || (state_d == S_LOAD) ||
                     (state_q == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      word_cnt_q     <= '0;
      step_q         <= '0;
      kern_cnt_q     <= '0;
      num_kernels_q  <= '0;
      job_ready_q    <= 1'b1;
      wht_in_ready_q <= 1'b0;
      config_mode_q  <= 1'b0;
      job_accept_q   <= 1'b0;
      wren_q         <= 1'b0;
      wdata_q        <= '0;
      addr0_q        <= '0;
      addr1_q        <= '0;
      pad_q          <= 1'b0;
      ce_execute_q   <= 1'b0;
      next_kernel_q  <= 1'b0;
      job_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      step_q         <= step_d;
      kern_cnt_q     <= kern_cnt_d;
      num_kernels_q  <= num_kernels_d;
      job_ready_q    <= job_ready_d;
      wht_in_ready_q <= wht_in_ready_d;
      config_mode_q  <= config_mode_d;
      job_accept_q   <= job_accept_d;
      wren_q         <= wren_d;
      wdata_q        <= wdata_d;
      addr0_q        <= addr0_d;
      addr1_q        <= addr1_d;
      pad_q          <= pad_d;
      ce_execute_q   <= ce_execute_d;
      next_kernel_q  <= next_kernel_d;
      job_done_q     <= job_done_d;
    end
  end

  assign job_ready       = job_ready_q;
  assign wht_in_ready    = wht_in_ready_q;
  assign config_mode     = config_mode_q;
  assign job_accept      = job_accept_q;
  assign num_kernels     = num_kernels_q;
  assign wht_config_wren = wren_q;
  assign wht_config_data = wdata_q;
  assign wht_seq_addr0   = addr0_q;
  assign wht_seq_addr1   = addr1_q;
  assign wht_seq_pad     = pad_q;
  assign ce_execute      = ce_execute_q;
  assign next_kernel     = next_kernel_q;
  assign job_done        = job_done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_table_ctrl.sv
// Directed bench for cnn_layer_accel_weight_table_ctrl. A job-level model
// lists every expected table write and every expected execute step; one
// negedge compare process pops those lists as the DUT produces them.
module tb_cnn_layer_accel_weight_table_ctrl;

  localparam int KW = 9;
  localparam int SL = 5;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [NW-1:0] job_num_kernels;
  logic          wht_in_valid;
  logic          wht_in_ready;
  logic [15:0]   wht_in_data;
  logic          exec_stall;
  logic          last_kernel;
  logic          config_mode;
  logic          job_accept;
  logic [NW-1:0] num_kernels;
  logic          wht_config_wren;
  logic [15:0]   wht_config_data;
  logic [3:0]    wht_seq_addr0;
  logic [3:0]    wht_seq_addr1;
  logic          wht_seq_pad;
  logic          ce_execute;
  logic          next_kernel;
  logic          job_done;

  cnn_layer_accel_weight_table_ctrl #(
    .C_KERNEL_WORDS(KW), .C_SEQ_LEN(SL), .C_NK_WIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_num_kernels(job_num_kernels),
    .wht_in_valid(wht_in_valid), .wht_in_ready(wht_in_ready),
    .wht_in_data(wht_in_data),
    .exec_stall(exec_stall), .last_kernel(last_kernel),
    .config_mode(config_mode), .job_accept(job_accept),
    .num_kernels(num_kernels),
    .wht_config_wren(wht_config_wren), .wht_config_data(wht_config_data),
    .wht_seq_addr0(wht_seq_addr0), .wht_seq_addr1(wht_seq_addr1),
    .wht_seq_pad(wht_seq_pad), .ce_execute(ce_execute),
    .next_kernel(next_kernel), .job_done(job_done)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard
  logic [15:0] exp_q[$];    // expected table writes
  logic [9:0]  exp_x_q[$];  // expected steps {addr0, addr1, pad, last}
  int          wren_cnt, ce_cnt, nk_cnt, done_cnt, cfg_cycles;
  bit          chk_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] word_ctr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=unexpected required=none", name);
  endtask

  always @(posedge clk) stall_prev <= exec_stall;

  always @(negedge clk) begin
    if (chk_en) begin
      if (config_mode) cfg_cycles++;
      if (wht_config_wren) begin
        wren_cnt++;
        if (exp_q.size() == 0) flag("wren_extra");
        else chk("wren_data", wht_config_data, exp_q.pop_front());
      end
      if (ce_execute) begin
        logic [9:0] e;
        ce_cnt++;
        if (stall_prev) flag("ce_during_stall");
        if (exp_x_q.size() == 0) flag("ce_extra");
        else begin
          e = exp_x_q.pop_front();
          chk("seq_addr0", wht_seq_addr0, e[9:6]);
          chk("seq_addr1", wht_seq_addr1, e[5:2]);
          chk("seq_pad", wht_seq_pad, e[1]);
          chk("next_kernel_step", next_kernel, e[0]);
        end
      end else if (next_kernel) begin
        flag("next_kernel_no_ce");
      end
      if (next_kernel) nk_cnt++;
      if (job_done) done_cnt++;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_job_ready"}, job_ready, 1);
    chk({tag, "_wht_in_ready"}, wht_in_ready, 0);
    chk({tag, "_config_mode"}, config_mode, 0);
    chk({tag, "_job_accept"}, job_accept, 0);
    chk({tag, "_num_kernels"}, num_kernels, 0);
    chk({tag, "_wren"}, wht_config_wren, 0);
    chk({tag, "_wdata"}, wht_config_data, 0);
    chk({tag, "_addr0"}, wht_seq_addr0, 0);
    chk({tag, "_addr1"}, wht_seq_addr1, 0);
    chk({tag, "_pad"}, wht_seq_pad, 0);
    chk({tag, "_ce"}, ce_execute, 0);
    chk({tag, "_next_kernel"}, next_kernel, 0);
    chk({tag, "_job_done"}, job_done, 0);
  endtask

  // driver tasks
  task automatic start_job(input int nk);
    int cyc = 0;
    wren_cnt = 0; ce_cnt = 0; nk_cnt = 0; done_cnt = 0; cfg_cycles = 0;
    word_ctr = 16'h0001;
    // Model: every kernel runs steps 0..SL-1 covering weight indices
    // 2i and 2i+1; an index past the last weight is padding.
    for (int k = 0; k <= nk; k++) begin
      for (int i = 0; i < SL; i++) begin
        logic [3:0] a0, a1;
        logic       p, l;
        a0 = 4'(2 * i);
        a1 = 4'(2 * i + 1);
        p  = (2 * i + 1 >= KW);
        l  = (i == SL - 1);
        exp_x_q.push_back({a0, a1, p, l});
      end
    end
    while (!job_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("job_ready_wait", job_ready, 1);
    job_valid = 1'b1;
    job_num_kernels = NW'(nk);
    @(negedge clk);
    job_valid = 1'b0;
    chk("job_accept_pulse", job_accept, 1);
    chk("num_kernels_latch", num_kernels, nk);
    chk("config_mode_accept", config_mode, 1);
    chk("job_ready_busy", job_ready, 0);
  endtask

  task automatic load_beats(input int n, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit v, rdy;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      rdy = wht_in_ready;
      v = toggle ? ~cyc[0] : 1'b1;
      wht_in_valid = v;
      wht_in_data = word_ctr;
      if (v && rdy) begin
        exp_q.push_back(word_ctr);
        word_ctr++;
        got++;
      end
      cyc++;
    end
    chk("load_beats_done", got, n);
  endtask

  // wht_in_valid is left high past the final beat on purpose; ready must
  // already be low so no extra word is written.
  task automatic finish_job(input int nk, input bit do_stall, input int lk_delay);
    int cyc = 0;
    bit stalled = 1'b0;
    while (nk_cnt < nk + 1 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) chk("no_ready_after_load", wht_in_ready, 0);
      if (cyc == 2) wht_in_valid = 1'b0;
      if (do_stall && !stalled && ce_execute && wht_seq_addr0 == 4'd2) begin
        stalled = 1'b1;
        exec_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          #1;
          cyc++;
          chk("stall_ce", ce_execute, 0);
          chk("stall_addr0", wht_seq_addr0, 4);
          chk("stall_addr1", wht_seq_addr1, 5);
          chk("stall_next_kernel", next_kernel, 0);
        end
        exec_stall = 1'b0;
      end
    end
    wht_in_valid = 1'b0;
    chk("exec_kernels", nk_cnt, nk + 1);
    if (do_stall) chk("stall_seen", stalled, 1);
    for (int d = 0; d < lk_delay; d++) begin
      job_valid = 1'b1;  // must not be taken while draining
      chk("drain_job_ready", job_ready, 0);
      chk("drain_job_done", job_done, 0);
      chk("drain_job_accept", job_accept, 0);
      @(negedge clk);
      #1;
    end
    job_valid = 1'b0;
    last_kernel = 1'b1;
    @(negedge clk);
    #1;
    chk("job_done_pulse", job_done, 1);
    chk("job_ready_after_done", job_ready, 1);
    last_kernel = 1'b0;
    @(negedge clk);
    #1;
    chk("job_done_single", job_done, 0);
    chk("job_done_count", done_cnt, 1);
    chk("job_accept_quiet", job_accept, 0);
    chk("wren_total", wren_cnt, (nk + 1) * KW);
    chk("ce_total", ce_cnt, (nk + 1) * SL);
    chk("wren_queue_empty", exp_q.size(), 0);
    chk("step_queue_empty", exp_x_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    job_num_kernels = '0;
    wht_in_valid = 1'b0;
    wht_in_data = '0;
    exec_stall = 1'b0;
    last_kernel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("init");
    rst = 1'b0;
    chk_en = 1'b1;

    // T1: single kernel, back-to-back weights 0x0001..0x0009
    start_job(0);
    load_beats(9, 1'b0);
    finish_job(0, 1'b0, 0);
    chk("t1_wren", wren_cnt, 9);
    chk("t1_config_cycles", cfg_cycles, 11);
    chk("t1_ce", ce_cnt, 5);
    chk("t1_next_kernel", nk_cnt, 1);

    // T2: three kernels, valid toggling every cycle
    start_job(2);
    load_beats(27, 1'b1);
    finish_job(2, 1'b0, 0);
    chk("t2_wren", wren_cnt, 27);
    chk("t2_next_kernel", nk_cnt, 3);

    // T3: 3-cycle stall ahead of step 2
    start_job(0);
    load_beats(9, 1'b0);
    finish_job(0, 1'b1, 0);
    chk("t3_ce", ce_cnt, 5);

    // T4: last_kernel arrives 10 cycles after the final next_kernel
    start_job(1);
    load_beats(18, 1'b0);
    finish_job(1, 1'b0, 10);
    chk("t4_next_kernel", nk_cnt, 2);

    // T5: reset in the middle of LOAD, then a fresh job
    start_job(2);
    load_beats(13, 1'b0);
    @(negedge clk);
    wht_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midload");
    chk("t5_wren_before_rst", wren_cnt, 13);
    rst = 1'b0;
    exp_q.delete();
    exp_x_q.delete();
    start_job(2);
    load_beats(27, 1'b0);
    finish_job(2, 1'b0, 0);
    chk("t5_next_kernel", nk_cnt, 3);

    // T6: maximum kernel count
    start_job(63);
    load_beats(576, 1'b0);
    finish_job(63, 1'b0, 0);
    chk("t6_wren", wren_cnt, 576);
    chk("t6_next_kernel", nk_cnt, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
